pin_entry_collector: RTL and testbench

Front end of the digital lock's keypad path. Synchronises and debounces the raw btn0 (enter digit) and btn1 (submit) push-buttons. Shifts the 4-bit sw value into a 16-bit code on each btn0 press. Hands the assembled code to the lock controller on btn1, as a single-cycle pulse with status flags; the controller then runs compare, error counting and LED/RGB display.

---
 rtl/pin_entry_collector_pkg.sv | 22 ++
 rtl/pin_entry_collector_btn_debounce.sv | 59 +++++
 rtl/pin_entry_collector.sv | 150 +++++++++++++++
 tb/tb_pin_entry_collector.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pin_entry_collector_pkg.sv
`default_nettype none
// pin_entry_collector_pkg: lock state encoding, digit count, default cycle constants. Rev 1.0
package pin_entry_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  localparam int unsigned CLK_HZ              = 125_000_000;
  localparam int unsigned DIGITS              = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;
  localparam int unsigned TIMEOUT_CYCLES_DEF  = CLK_HZ * 5;

  // Bits needed for a counter running 0 .. max_count-1.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pin_entry_collector_btn_debounce.sv
`default_nettype none
// btn_debounce: 2-FF synchroniser, stable-count debouncer, registered rising-edge press pulse. Rev 1.0
module btn_debounce
  import pin_entry_collector_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          level_prev_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
      cnt_q        <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/pin_entry_collector.sv
`default_nettype none
// pin_entry_collector: debounced keypad front end assembling a DIGITS-nibble code for the lock controller. Rev 1.0
module pin_entry_collector
  import pin_entry_collector_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn0,
  input  logic                btn1,
  input  logic [3:0]          sw,
  input  logic                enb_inp,
  output logic [4*DIGITS-1:0] value_16bit,
  output logic [2:0]          digit_cnt,
  output logic                entry_done,
  output logic                entry_short,
  output logic                entry_timeout,
  output logic                busy
);

  localparam int unsigned   VW       = 4 * DIGITS;
  localparam int unsigned   TW       = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    DIG_CNT  = 3'(DIGITS);

  logic          w_press0;
  logic          w_press1;
  logic [VW-1:0] w_shift;

  state_e        state_q,   state_d;
  logic [VW-1:0] value_q,   value_d;
  logic [2:0]    cnt_q,     cnt_d;
  logic [TW-1:0] timer_q,   timer_d;
  logic          clear_q,   clear_d;
  logic          done_q,    done_d;
  logic          short_q,   short_d;
  logic          timeout_q, timeout_d;
  logic          busy_q,    busy_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn0_deb (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn0),
    .press_o (w_press0)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn1_deb (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn1),
    .press_o (w_press1)
  );

  assign w_shift = (value_q << 4) | VW'(sw);

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    cnt_d     = cnt_q;
    timer_d   = '0;
    clear_d   = 1'b0;
    done_d    = 1'b0;
    short_d   = 1'b0;
    timeout_d = 1'b0;
    if (!enb_inp) begin
      state_d = ST_IDLE;
      value_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A submitted code stays visible for its done/short cycle, then clears here.
          if (clear_q) begin
            value_d = '0;
            cnt_d   = '0;
          end
          if (w_press1) begin
            short_d = 1'b1;
          end else if (w_press0) begin
            value_d = VW'(sw);
            cnt_d   = 3'd1;
            state_d = (DIGITS == 1) ? ST_FULL : ST_COLLECT;
          end
        end
        ST_COLLECT, ST_FULL: begin
          if (w_press1) begin
            done_d  = (state_q == ST_FULL);
            short_d = (state_q == ST_COLLECT);
            clear_d = 1'b1;
            state_d = ST_IDLE;
          end else if (w_press0 && (state_q == ST_COLLECT)) begin
            value_d = w_shift;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q + 3'd1 == DIG_CNT) begin
              state_d = ST_FULL;
            end
          end else if (timer_q == TMO_LAST) begin
            timeout_d = 1'b1;
            value_d   = '0;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          value_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      value_q   <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      clear_q   <= 1'b0;
      done_q    <= 1'b0;
      short_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      clear_q   <= clear_d;
      done_q    <= done_d;
      short_q   <= short_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign value_16bit   = value_q;
  assign digit_cnt     = cnt_q;
  assign entry_done    = done_q;
  assign entry_short   = short_q;
  assign entry_timeout = timeout_q;
  assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_pin_entry_collector.sv
`default_nettype none
// tb_pin_entry_collector: randomized scenarios checked against a digit-queue model of the keypad entry. Rev 1.0
module tb_pin_entry_collector;
  import pin_entry_collector_pkg::*;

  localparam int DEB = 4;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn0 = 1'b0;
  logic        btn1 = 1'b0;
  logic        enb_inp = 1'b1;
  logic [3:0]  sw = 4'h0;
  logic [15:0] value_16bit;
  logic [2:0]  digit_cnt;
  logic        entry_done;
  logic        entry_short;
  logic        entry_timeout;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int seen_done = 0, seen_short = 0, seen_tmo = 0;
  int m_done    = 0, m_short    = 0, m_tmo    = 0;
  logic [3:0] m_dig[$];

  pin_entry_collector #(
    .DEBOUNCE_CYCLES (DEB),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn0          (btn0),
    .btn1          (btn1),
    .sw            (sw),
    .enb_inp       (enb_inp),
    .value_16bit   (value_16bit),
    .digit_cnt     (digit_cnt),
    .entry_done    (entry_done),
    .entry_short   (entry_short),
    .entry_timeout (entry_timeout),
    .busy          (busy)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      seen_done  <= seen_done  + int'(entry_done);
      seen_short <= seen_short + int'(entry_short);
      seen_tmo   <= seen_tmo   + int'(entry_timeout);
    end
  end

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required < 50000", cyc);
    $fatal(1, "watchdog expired");
  end

  // Code as seen by the controller: digits in entry order, last digit in the low nibble.
  function automatic logic [15:0] m_value();
    logic [15:0] r;
    r = '0;
    foreach (m_dig[i]) r = 16'(r * 16'd16 + 16'(m_dig[i]));
    return r;
  endfunction

  function automatic void model_press(input bit p0, input bit p1, input logic [3:0] v);
    if (!enb_inp) return;
    if (p1) begin
      if (m_dig.size() == int'(DIGITS)) m_done++;
      else m_short++;
      m_dig.delete();
    end else if (p0 && m_dig.size() < int'(DIGITS)) begin
      m_dig.push_back(v);
    end
  endfunction

  // Returns at the negedge just before the press takes effect (DEB+3 edges after the final rise).
  task automatic drive_to_event(input bit b0, input bit b1, input logic [3:0] v, input bit bouncy);
    @(negedge clk);
    sw = v;
    if (bouncy) begin
      for (int i = 0; i < 12; i++) begin
        if (b0) btn0 = ((i / 2) % 2 == 0);
        if (b1) btn1 = ((i / 2) % 2 == 0);
        @(negedge clk);
      end
    end
    if (b0) btn0 = 1'b1;
    if (b1) btn1 = 1'b1;
    repeat (DEB + 3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_btns(input int hold);
    repeat (hold) @(negedge clk);
    sw   = 4'($urandom);
    btn0 = 1'b0;
    btn1 = 1'b0;
    repeat (DEB + 5) @(negedge clk);
  endtask

  task automatic enter_digit(input logic [3:0] v, input bit bouncy);
    drive_to_event(1'b1, 1'b0, v, bouncy);
    @(negedge clk);
    model_press(1'b1, 1'b0, v);
    release_btns($urandom_range(0, 4));
  endtask

  task automatic do_submit(input string tag, input bit with_b0, input bit bouncy);
    logic [15:0] exp_v;
    bit          exp_full;
    exp_v    = m_value();
    exp_full = (m_dig.size() == int'(DIGITS));
    drive_to_event(with_b0, 1'b1, 4'($urandom), bouncy);
    @(negedge clk);
    model_press(with_b0, 1'b1, 4'h0);
    n_checks++;
    if (entry_done !== exp_full || entry_short !== !exp_full)
      $display("FAIL %s_flags: done=%b short=%b, required done=%b short=%b", tag, entry_done, entry_short, exp_full, !exp_full);
    else n_pass++;
    if (exp_full) begin
      n_checks++;
      if (value_16bit !== exp_v || digit_cnt !== 3'(DIGITS))
        $display("FAIL %s_value: value=%h cnt=%0d, required value=%h cnt=%0d", tag, value_16bit, digit_cnt, exp_v, DIGITS);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if ({value_16bit, digit_cnt, busy, entry_done, entry_short} !== 21'h0)
      $display("FAIL %s_clear: value=%h cnt=%0d busy=%b done=%b short=%b, required all 0", tag, value_16bit, digit_cnt, busy, entry_done, entry_short);
    else n_pass++;
    release_btns($urandom_range(0, 3));
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({value_16bit, digit_cnt, entry_done, entry_short, entry_timeout, busy} !== 23'h0)
      $display("FAIL reset_state: value=%h cnt=%0d busy=%b, required all 0", value_16bit, digit_cnt, busy);
    else n_pass++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({value_16bit, digit_cnt, busy} !== 20'h0)
      $display("FAIL post_reset_idle: value=%h cnt=%0d busy=%b, required 0", value_16bit, digit_cnt, busy);
    else n_pass++;
  endtask

  task automatic test_latency();
    drive_to_event(1'b1, 1'b0, 4'h3, 1'b0);
    n_checks++;
    if (value_16bit !== 16'h0 || digit_cnt !== 3'd0)
      $display("FAIL latency_early: value=%h cnt=%0d one cycle before DEB+3, required 0000/0", value_16bit, digit_cnt);
    else n_pass++;
    @(negedge clk);
    model_press(1'b1, 1'b0, 4'h3);
    n_checks++;
    if (value_16bit !== 16'h0003 || digit_cnt !== 3'd1 || busy !== 1'b1)
      $display("FAIL latency_press: value=%h cnt=%0d busy=%b, required 0003/1/1", value_16bit, digit_cnt, busy);
    else n_pass++;
    release_btns(3);
    do_submit("latency_submit", 1'b0, 1'b0);
  endtask

  task automatic test_bounce();
    for (int d = 1; d <= 4; d++) enter_digit(4'(d), 1'b1);
    n_checks++;
    if (value_16bit !== 16'h1234 || digit_cnt !== 3'd4 || busy !== 1'b1)
      $display("FAIL bounce_collect: value=%h cnt=%0d busy=%b, required 1234/4/1", value_16bit, digit_cnt, busy);
    else n_pass++;
    do_submit("bounce_submit", 1'b0, 1'b1);
    n_checks++;
    if (seen_done !== m_done || seen_short !== m_short || seen_tmo !== m_tmo)
      $display("FAIL bounce_pulses: done=%0d short=%0d tmo=%0d, required %0d/%0d/%0d", seen_done, seen_short, seen_tmo, m_done, m_short, m_tmo);
    else n_pass++;
  endtask

  task automatic test_full_ignore();
    enter_digit(4'hA, 1'b0);
    enter_digit(4'hB, 1'b0);
    enter_digit(4'hC, 1'b0);
    enter_digit(4'hD, 1'b0);
    enter_digit(4'hF, 1'b0);
    n_checks++;
    if (value_16bit !== 16'hABCD || digit_cnt !== 3'd4)
      $display("FAIL full_ignore: value=%h cnt=%0d, required ABCD/4", value_16bit, digit_cnt);
    else n_pass++;
    do_submit("full_submit", 1'b0, 1'b0);
  endtask

  task automatic test_short();
    enter_digit(4'h6, 1'b0);
    enter_digit(4'h2, 1'b0);
    do_submit("short_collect", 1'b0, 1'b0);
    do_submit("short_idle", 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int ev;
    drive_to_event(1'b1, 1'b0, 4'h9, 1'b0);
    @(negedge clk);
    model_press(1'b1, 1'b0, 4'h9);
    ev = cyc;
    release_btns(1);
    while (cyc < ev + TMO - 1) @(negedge clk);
    n_checks++;
    if (entry_timeout !== 1'b0 || busy !== 1'b1 || value_16bit !== 16'h0009)
      $display("FAIL timeout_early: tmo=%b busy=%b value=%h, required 0/1/0009", entry_timeout, busy, value_16bit);
    else n_pass++;
    @(negedge clk);
    m_dig.delete();
    m_tmo++;
    n_checks++;
    if (entry_timeout !== 1'b1 || busy !== 1'b0 || value_16bit !== 16'h0 || digit_cnt !== 3'd0)
      $display("FAIL timeout_fire: tmo=%b busy=%b value=%h cnt=%0d, required 1/0/0000/0", entry_timeout, busy, value_16bit, digit_cnt);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (entry_timeout !== 1'b0)
      $display("FAIL timeout_pulse_width: tmo=%b, required 0", entry_timeout);
    else n_pass++;
  endtask

  task automatic test_enable();
    enter_digit(4'h5, 1'b0);
    enter_digit(4'h6, 1'b0);
    @(negedge clk);
    enb_inp = 1'b0;
    m_dig.delete();
    @(negedge clk);
    n_checks++;
    if ({value_16bit, digit_cnt, busy} !== 20'h0)
      $display("FAIL enable_clear: value=%h cnt=%0d busy=%b, required 0", value_16bit, digit_cnt, busy);
    else n_pass++;
    drive_to_event(1'b1, 1'b0, 4'h7, 1'b0);
    @(negedge clk);
    model_press(1'b1, 1'b0, 4'h7);
    enb_inp = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    n_checks++;
    if ({value_16bit, digit_cnt, busy} !== 20'h0)
      $display("FAIL enable_blocked: value=%h cnt=%0d busy=%b, required 0", value_16bit, digit_cnt, busy);
    else n_pass++;
    release_btns(0);
    n_checks++;
    if (seen_done !== m_done || seen_short !== m_short || seen_tmo !== m_tmo)
      $display("FAIL enable_pulses: done=%0d short=%0d tmo=%0d, required %0d/%0d/%0d", seen_done, seen_short, seen_tmo, m_done, m_short, m_tmo);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    enter_digit(4'h8, 1'b0);
    enter_digit(4'h1, 1'b0);
    enter_digit(4'h4, 1'b0);
    do_submit("simultaneous", 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_entry();
    enter_digit(4'h2, 1'b0);
    enter_digit(4'hE, 1'b0);
    enter_digit(4'h5, 1'b0);
    @(negedge clk);
    sw   = 4'h7;
    btn0 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    m_dig.delete();
    n_checks++;
    if ({value_16bit, digit_cnt, entry_done, entry_short, entry_timeout, busy} !== 23'h0)
      $display("FAIL reset_mid_entry: value=%h cnt=%0d busy=%b, required all 0", value_16bit, digit_cnt, busy);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (DEB + 3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (digit_cnt !== 3'd0)
      $display("FAIL reset_held_early: cnt=%0d, required 0", digit_cnt);
    else n_pass++;
    @(negedge clk);
    model_press(1'b1, 1'b0, 4'h7);
    n_checks++;
    if (value_16bit !== 16'h0007 || digit_cnt !== 3'd1 || busy !== 1'b1)
      $display("FAIL reset_held_press: value=%h cnt=%0d busy=%b, required 0007/1/1", value_16bit, digit_cnt, busy);
    else n_pass++;
    release_btns(3);
    n_checks++;
    if (value_16bit !== m_value() || digit_cnt !== 3'(m_dig.size()))
      $display("FAIL reset_single_press: value=%h cnt=%0d, required %h/%0d", value_16bit, digit_cnt, m_value(), m_dig.size());
    else n_pass++;
    do_submit("reset_submit", 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int e = 0; e < 6; e++) begin
      n = $urandom_range(0, 6);
      for (int j = 0; j < n; j++) begin
        enter_digit(4'($urandom), 1'($urandom_range(0, 1)));
        n_checks++;
        if (value_16bit !== m_value() || digit_cnt !== 3'(m_dig.size()) || busy !== (m_dig.size() > 0))
          $display("FAIL random_digit: value=%h cnt=%0d busy=%b, required %h/%0d/%b", value_16bit, digit_cnt, busy, m_value(), m_dig.size(), m_dig.size() > 0);
        else n_pass++;
      end
      do_submit("random_submit", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    n_checks++;
    if (seen_done !== m_done || seen_short !== m_short || seen_tmo !== m_tmo)
      $display("FAIL random_pulses: done=%0d short=%0d tmo=%0d, required %0d/%0d/%0d", seen_done, seen_short, seen_tmo, m_done, m_short, m_tmo);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_full_ignore();
    test_short();
    test_timeout();
    test_enable();
    test_simultaneous();
    test_reset_mid_entry();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
